// File: rtl/uart_rx_ascii.sv
// 8N1 LSB-first UART receiver feeding the PWM duty stage.
// data_out holds the last well-framed byte. data_valid and frame_err are one-cycle pulses.
module uart_rx_ascii #(
  parameter int          CLKS_PER_BIT = 5208,
  parameter logic [7:0]  RESET_BYTE   = 8'h30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  // state     | meaning
  // IDLE      | line idle, baud counter held at 0
  // START     | start bit seen, confirm it at mid-bit
  // DATA      | sample 8 data bits at full-bit points (mid-bit in line time)
  // STOP      | check stop bit, publish byte or flag framing error
  // WAIT_IDLE | line stuck low after a bad stop bit, wait for it to go high
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_IDLE = 3'd4;

  localparam logic [15:0] HALF_CNT = 16'((CLKS_PER_BIT - 1) / 2);
  localparam logic [15:0] FULL_CNT = 16'(CLKS_PER_BIT - 1);

  logic        rx_meta_q, rx_s_q;
  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        dv_q, dv_d;
  logic        fe_q, fe_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    fe_d    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = 16'd0;
        idx_d = 3'd0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        // Restarting the count here puts every later full-bit point mid-bit.
        if (cnt_q == HALF_CNT) begin
          cnt_d   = 16'd0;
          state_d = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d          = 16'd0;
          shift_d[idx_q] = rx_s_q;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d = 16'd0;
          if (rx_s_q) begin
            data_d  = shift_q;
            dv_d    = 1'b1;
            state_d = IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        cnt_d = 16'd0;
        if (rx_s_q) state_d = IDLE;
      end
      default: begin
        cnt_d   = 16'd0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      idx_q   <= 3'd0;
      shift_q <= 8'd0;
      data_q  <= RESET_BYTE;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      fe_q    <= fe_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = dv_q;
  assign frame_err  = fe_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_ascii.sv
// Bench for uart_rx_ascii: a fast instance (16 clks/bit) checked against a frame-event
// model every cycle, plus two default-rate instances fed at +2% and -2% baud error.
module tb_uart_rx_ascii;

  localparam int CPB   = 16;
  localparam int LAT   = 2 + (CPB - 1) / 2 + 9 * CPB;
  localparam int CPB_D = 5208;
  localparam int LAT_D = 2 + (CPB_D - 1) / 2 + 9 * CPB_D;

  logic       clk = 1'b0;
  logic       rst_n, rst_def_n;
  logic       rx;
  logic [7:0] dout;
  logic       dv, fe, busy;

  logic       rx_d   [2];
  logic [7:0] dout_d [2];
  logic       dv_d   [2];
  logic       fe_d   [2];
  logic       busy_d [2];

  int cyc = 0;
  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_ascii #(.CLKS_PER_BIT(CPB), .RESET_BYTE(8'h30)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .data_out(dout),
    .data_valid(dv), .frame_err(fe), .busy(busy)
  );

  for (genvar g = 0; g < 2; g++) begin : g_def
    uart_rx_ascii u_def (
      .clk(clk), .rst_n(rst_def_n), .rx(rx_d[g]), .data_out(dout_d[g]),
      .data_valid(dv_d[g]), .frame_err(fe_d[g]), .busy(busy_d[g])
    );
  end

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: each transmitted frame yields one expected pulse at a fixed latency.
  typedef struct {
    logic       err;
    logic [7:0] b;
    int         t;
  } ev_t;
  ev_t q[$];
  logic [7:0] exp_data = 8'h30;
  int n_dv = 0, n_fe = 0, last_lat = 0, last_dv = 0, prev_dv = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_data = 8'h30;
      chk("rst_data_out", dout, 8'h30);
      chk("rst_data_valid", dv, 0);
      chk("rst_frame_err", fe, 0);
      chk("rst_busy", busy, 0);
    end else begin
      if (dv || fe) begin
        chk("dv_fe_exclusive", int'(dv && fe), 0);
        if (dv) n_dv++;
        if (fe) n_fe++;
        if (q.size() == 0) begin
          chk("spurious_pulse", 1, 0);
        end else begin
          ev_t e;
          e = q.pop_front();
          last_lat = cyc - e.t;
          chk("pulse_kind_frame_err", fe, e.err);
          nchk++;
          if (last_lat < LAT - 1 || last_lat > LAT + 1) begin
            nerr++;
            $display("FAIL latency: got %0d cycles, expected %0d..%0d", last_lat, LAT - 1, LAT + 1);
          end
          if (dv && !e.err) exp_data = e.b;
          if (dv) begin
            prev_dv = last_dv;
            last_dv = cyc;
          end
        end
      end else if (q.size() != 0 && (cyc - q[0].t) > LAT + 1) begin
        chk("missing_pulse", 0, 1);
        void'(q.pop_front());
      end
      chk("data_out", dout, exp_data);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 so frames can be chained with no gap.
  task automatic send(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    ev_t e;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = fr[i];
      if (i == 0) begin
        e.err = ~stop;
        e.b   = b;
        e.t   = cyc + 1;
        q.push_back(e);
      end
      repeat (CPB) @(posedge clk);
      #1;
    end
  endtask

  // Default-rate instances: one transmitter, two bit periods (102% and 98%).
  int   def_ndv [2] = '{0, 0};
  int   def_nfe [2] = '{0, 0};
  int   def_lat [2] = '{0, 0};
  int   def_t = 0;
  logic def_done = 1'b0;

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rst_def_n && dv_d[g]) begin
        def_ndv[g]++;
        def_lat[g] = cyc - def_t;
      end
      if (rst_def_n && fe_d[g]) def_nfe[g]++;
    end
  end

  initial begin
    logic [9:0] fr;
    int base, e, idx;
    int pct [2];
    pct = '{102, 98};
    fr  = {1'b1, 8'h34, 1'b0};
    rx_d[0] = 1'b1;
    rx_d[1] = 1'b1;
    wait (rst_def_n === 1'b1);
    idle(20);
    base  = cyc;
    def_t = cyc + 1;
    e = 0;
    while (e < (10 * CPB_D * 102) / 100 + 50) begin
      for (int g = 0; g < 2; g++) begin
        idx = (e * 100) / (CPB_D * pct[g]);
        rx_d[g] = (idx >= 9) ? 1'b1 : fr[idx];
      end
      @(posedge clk);
      #1;
      e = cyc - base;
    end
    def_done = 1'b1;
  end

  initial begin
    int base_dv, base_fe;
    rst_n = 1'b0;
    rst_def_n = 1'b0;
    rx = 1'b1;
    idle(3);
    rst_n = 1'b1;
    rst_def_n = 1'b1;
    idle(20);
    chk("post_reset_busy", busy, 0);
    chk("post_reset_data_out", dout, 8'h30);

    send(8'h35, 1'b1);
    chk("f35_data_out", dout, 8'h35);
    chk("f35_latency", last_lat, 154);
    chk("f35_ndv", n_dv, 1);
    idle(1000);
    chk("f35_hold_data_out", dout, 8'h35);

    base_fe = n_fe;
    send(8'h31, 1'b1);
    send(8'h39, 1'b1);
    idle(30);
    chk("b2b_spacing", last_dv - prev_dv, 10 * CPB);
    chk("b2b_data_out", dout, 8'h39);
    chk("b2b_ndv", n_dv, 3);
    chk("b2b_no_frame_err", n_fe, base_fe);

    send(8'h35, 1'b1);
    idle(10);
    base_dv = n_dv;
    send(8'h37, 1'b0);
    idle(100);
    chk("stoplow_frame_err", n_fe, base_fe + 1);
    chk("stoplow_no_dv", n_dv, base_dv);
    chk("stoplow_data_out", dout, 8'h35);
    chk("wait_idle_busy", busy, 1);
    rx = 1'b1;
    idle(10);
    chk("wait_idle_exit_busy", busy, 0);
    send(8'h32, 1'b1);
    idle(20);
    chk("after_err_data_out", dout, 8'h32);

    base_dv = n_dv;
    base_fe = n_fe;
    rx = 1'b0;
    idle(5);
    rx = 1'b1;
    idle(40);
    chk("glitch_busy", busy, 0);
    chk("glitch_no_dv", n_dv, base_dv);
    chk("glitch_no_fe", n_fe, base_fe);
    chk("glitch_data_out", dout, 8'h32);

    rx = 1'b0;
    idle(3 * CPB + 5);
    rx = 1'b1;
    idle(10);
    chk("midframe_busy", busy, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_data_out", dout, 8'h30);
    chk("async_rst_dv", dv, 0);
    chk("async_rst_fe", fe, 0);
    chk("async_rst_busy", busy, 0);
    idle(4);
    rst_n = 1'b1;
    idle(200);
    chk("rst_release_busy", busy, 0);
    chk("rst_release_data_out", dout, 8'h30);

    wait (def_done === 1'b1);
    idle(5);
    for (int g = 0; g < 2; g++) begin
      chk("def_ndv", def_ndv[g], 1);
      chk("def_nfe", def_nfe[g], 0);
      chk("def_data_out", dout_d[g], 8'h34);
      nchk++;
      if (def_lat[g] < LAT_D - 1 || def_lat[g] > LAT_D + 1) begin
        nerr++;
        $display("FAIL def_latency[%0d]: got %0d cycles, expected %0d..%0d", g, def_lat[g], LAT_D - 1, LAT_D + 1);
      end
    end
    chk("model_queue_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/uart_rx_ascii.md
Name: uart_rx_ascii

Overview:
- Serial UART receiver (8N1, LSB first) that turns the host link into the 8-bit command byte for the PWM duty-cycle stage.
- The PWM stage samples its 8-bit input as a level on every clock, so this block holds the last good byte on data_out until a new frame completes without error.
- Also emits a one-cycle strobe per byte and error flags for debug LEDs.

Parameters:
- CLKS_PER_BIT, 5208, clk cycles per bit (50 MHz / 9600 baud); legal range 4..65535.
- RESET_BYTE, 8'h30, value of data_out after reset (ASCII '0', i.e. 0% duty downstream).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- rx  in  1  serial line, asynchronous to clk, idle high.
- data_out  out  8  last correctly framed byte, held between frames.
- data_valid  out  1  one-cycle pulse when data_out is updated.
- frame_err  out  1  one-cycle pulse when the stop bit is sampled low.
- busy  out  1  high while in any state other than IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; both synchronizer flops=1; bit counter and baud counter=0.
  - data_out=RESET_BYTE; data_valid=0; frame_err=0; busy=0.
- Input conditioning: rx passes through a 2-FF synchronizer (rx_s); all decisions use rx_s only.
- Baud counter: 16-bit, counts 0..CLKS_PER_BIT-1.
  - Mid-bit point: count==(CLKS_PER_BIT-1)/2 (integer divide).
  - Full-bit point: count==CLKS_PER_BIT-1, after which the counter wraps to 0.
- FSM:
  - IDLE: baud counter held at 0. rx_s==0 -> START.
  - START: at the mid-bit point, if rx_s==0 go to DATA and reset the baud counter so later samples land mid-bit; if rx_s==1 (glitch or false start) return to IDLE with no output.
  - DATA: at each full-bit point, sample rx_s into shift register bit[idx], idx 0..7, LSB first. After idx 7 -> STOP.
  - STOP: at the full-bit point (middle of the stop bit):
    - rx_s==1: data_out<=shift register, data_valid=1 for exactly one cycle, next state IDLE.
    - rx_s==0: frame_err=1 for exactly one cycle, data_out unchanged, next state WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s==1 (break or continuous low line), then IDLE. No outputs.
- Returning to IDLE at mid-stop lets a back-to-back start bit, arriving half a bit later, be caught.
- Latency: data_valid rises 2 + (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT (±1) clk cycles after the rx start-bit falling edge. data_out changes on the same edge data_valid rises.
- No content filtering: every well-framed byte, ASCII digit or not, updates data_out. The downstream stage ignores non-digits.
- data_valid and frame_err are never high together. Neither is high outside STOP exit cycles.
- busy=1 in START, DATA, STOP and WAIT_IDLE.
- Reset asserted mid-frame: immediate return to reset values. The partial byte is discarded and data_out reverts to RESET_BYTE.
- rx held low through reset release: block enters START on the first cycle after the synchronizer shows 0 and completes normally. If the line stays low, the result is a frame_err pulse then WAIT_IDLE.

Test Plan:
- Reset check (CLKS_PER_BIT=16): assert rst_n low mid-byte -> data_out=8'h30, data_valid=0, frame_err=0, busy=0 immediately (async). Release -> IDLE, no spurious pulse.
- Single frame 0x35 ('5') at 16 clks/bit -> data_valid pulses once at ~154 cycles after the start edge; data_out=8'h35 and remains 8'h35 for 1000 further idle cycles.
- Back-to-back frames 0x31 then 0x39 with zero idle gap -> two data_valid pulses spaced 10*16 cycles apart; data_out ends at 8'h39; frame_err never asserted.
- Stop bit forced low on frame 0x37 -> frame_err one-cycle pulse, no data_valid, data_out keeps the previous value (8'h35). Hold rx low 100 cycles -> stays in WAIT_IDLE (busy=1). rx high -> IDLE, and the next frame 0x32 is received correctly.
- Glitch: rx low for 5 cycles (< half bit at 16 clks/bit) -> back to IDLE, no data_valid, no frame_err, data_out unchanged.
- Default parameter CLKS_PER_BIT=5208, 9600-baud stimulus of 0x34 with ±2% baud error on the TX model -> data_out=8'h34 with one data_valid pulse.
